audio_stream_ctrl: RTL

Sequences codec sample flow through one shared 24-bit processing engine, such as a FIR or noise-add stage, time-multiplexed between the left and right channels. It accepts a stereo pair from the codec read port, sends left then right through the engine using a start/done handshake, and buffers the processed pairs in a small FIFO. It drains that FIFO to the codec write port. It sits between audio_codec and the filter datapath in the top level.

---
 rtl/audio_stream_ctrl.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/audio_stream_ctrl.sv
// audio_stream_ctrl
//   Moves stereo pairs from the codec read port through one shared sample
//   engine (left then right, start/done handshake) into a show-ahead output
//   FIFO, and drains that FIFO to the codec write port.
//
// Ports
//   CLOCK_50, reset                  : clock, synchronous active-high reset
//   bypass                           : 1 = raw samples skip the engine
//   read_ready, readdata_left/right  : codec input side
//   read                             : one-cycle pop strobe to codec input
//   write_ready, write               : codec output handshake
//   writedata_left/right             : FIFO head pair
//   eng_start, eng_ch, eng_in        : engine request (ch 0 = L, 1 = R)
//   eng_done, eng_out                : engine result
//   fifo_count                       : pairs buffered
//   timeout_err                      : sticky engine timeout flag
//   underrun_cnt                     : only with AUDIO_STREAM_UNDERRUN_CNT_EN
//
// Optional build macro: AUDIO_STREAM_UNDERRUN_CNT_EN adds underrun_cnt, a
// saturating count of write_ready rising edges seen while the FIFO is empty.
module audio_stream_ctrl #(
  parameter int DW      = 24,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     bypass,
  input  logic                     read_ready,
  input  logic [DW-1:0]            readdata_left,
  input  logic [DW-1:0]            readdata_right,
  output logic                     read,
  input  logic                     write_ready,
  output logic                     write,
  output logic [DW-1:0]            writedata_left,
  output logic [DW-1:0]            writedata_right,
  output logic                     eng_start,
  output logic                     eng_ch,
  output logic [DW-1:0]            eng_in,
  input  logic                     eng_done,
  input  logic [DW-1:0]            eng_out,
  output logic [$clog2(DEPTH):0]   fifo_count,
`ifdef AUDIO_STREAM_UNDERRUN_CNT_EN
  output logic [15:0]              underrun_cnt,
`endif
  output logic                     timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CAP    = 3'd1;
  localparam logic [2:0] S_WAIT_L = 3'd2;
  localparam logic [2:0] S_WAIT_R = 3'd3;
  localparam logic [2:0] S_PUSH   = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [DW-1:0]   cap_l_q, cap_l_d, cap_r_q, cap_r_d;
  logic [DW-1:0]   res_l_q, res_l_d, res_r_q, res_r_d;
  logic            start_q, start_d;
  logic            ch_q, ch_d;
  logic [DW-1:0]   ein_q, ein_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

  logic [2*DW-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d, avail;
  logic [2*DW-1:0] head_q, head_d;

  logic full, empty, rd_go, push, pop, done_v, tmo;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  // Gated with reset so every output reads 0 while reset is held.
  assign rd_go  = (state_q == S_IDLE) && read_ready && !full && !reset;
  assign pop    = write_ready && !empty && !reset;
  assign push   = (state_q == S_PUSH);
  // A done coinciding with our own start belongs to an earlier request.
  assign done_v = eng_done && !start_q;
  assign tmo    = (cnt_q == TW'(TIMEOUT));

  assign read            = rd_go;
  assign write           = pop;
  assign writedata_left  = head_q[2*DW-1:DW];
  assign writedata_right = head_q[DW-1:0];
  assign eng_start       = start_q;
  assign eng_ch          = ch_q;
  assign eng_in          = ein_q;
  assign fifo_count      = count_q;
  assign timeout_err     = err_q;

  always_comb begin
    state_d = state_q;
    cap_l_d = cap_l_q;
    cap_r_d = cap_r_q;
    res_l_d = res_l_q;
    res_r_d = res_r_q;
    start_d = 1'b0;
    ch_d    = ch_q;
    ein_d   = ein_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (rd_go) begin
          cap_l_d = readdata_left;
          cap_r_d = readdata_right;
          state_d = S_CAP;
        end
      end
      S_CAP: begin
        if (bypass) begin
          res_l_d = cap_l_q;
          res_r_d = cap_r_q;
          state_d = S_PUSH;
        end else begin
          start_d = 1'b1;
          ch_d    = 1'b0;
          ein_d   = cap_l_q;
          cnt_d   = '0;
          state_d = S_WAIT_L;
        end
      end
      S_WAIT_L: begin
        if (done_v || tmo) begin
          // On timeout the raw sample stands in for the missing result.
          res_l_d = done_v ? eng_out : cap_l_q;
          err_d   = err_q | !done_v;
          start_d = 1'b1;
          ch_d    = 1'b1;
          ein_d   = cap_r_q;
          cnt_d   = '0;
          state_d = S_WAIT_R;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_R: begin
        if (done_v || tmo) begin
          res_r_d = done_v ? eng_out : cap_r_q;
          err_d   = err_q | !done_v;
          state_d = S_PUSH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PUSH:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    avail    = count_q - CW'(pop);
    count_d  = avail + CW'(push);
    head_d   = head_q;
    // Show-ahead head: the pair being pushed becomes the head when nothing
    // older remains; otherwise the entry at the next read pointer.
    if (push && (avail == '0)) begin
      head_d = {res_l_q, res_r_q};
    end else if (avail != '0) begin
      head_d = mem[rd_ptr_d];
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      mem[wr_ptr_q] <= {res_l_q, res_r_q};
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cap_l_q  <= '0;
      cap_r_q  <= '0;
      res_l_q  <= '0;
      res_r_q  <= '0;
      start_q  <= 1'b0;
      ch_q     <= 1'b0;
      ein_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      state_q  <= state_d;
      cap_l_q  <= cap_l_d;
      cap_r_q  <= cap_r_d;
      res_l_q  <= res_l_d;
      res_r_q  <= res_r_d;
      start_q  <= start_d;
      ch_q     <= ch_d;
      ein_q    <= ein_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

`ifdef AUDIO_STREAM_UNDERRUN_CNT_EN
  logic        wr_prev_q;
  logic [15:0] urun_q, urun_d;

  always_comb begin
    urun_d = urun_q;
    if (write_ready && !wr_prev_q && empty && (urun_q != 16'hFFFF)) begin
      urun_d = urun_q + 16'd1;
    end
  end

  // wr_prev_q tracks write_ready through reset so a level already high at
  // reset release is not mistaken for a rising edge.
  always_ff @(posedge CLOCK_50) begin
    wr_prev_q <= write_ready;
    if (reset) begin
      urun_q <= '0;
    end else begin
      urun_q <= urun_d;
    end
  end

  assign underrun_cnt = urun_q;
`endif

endmodule
